// File: rtl/clk_ss_gen_if.sv
// Control and display bundle of the hh:mm:ss timekeeper.
// The master side drives buttons, mode and alarm settings; the slave side is the timekeeper.
interface clk_ss_gen_if;
    logic        btn_clr;
    logic        btn_min;
    logic        btn_hour;
    logic        mode_12h;
    logic        alarm_en;
    logic [4:0]  alarm_hour;
    logic [5:0]  alarm_min;
    logic [23:0] time_bcd;
    logic        pm;
    logic        sec_pulse;
    logic        alarm_hit;

    modport master (
        output btn_clr, btn_min, btn_hour, mode_12h, alarm_en, alarm_hour, alarm_min,
        input  time_bcd, pm, sec_pulse, alarm_hit
    );

    modport slave (
        input  btn_clr, btn_min, btn_hour, mode_12h, alarm_en, alarm_hour, alarm_min,
        output time_bcd, pm, sec_pulse, alarm_hit
    );
endinterface

// File: rtl/clk_ss_gen.sv
// Parametrised hh:mm:ss timekeeper: seconds prescaler, button setting with
// hold/auto-repeat, 12/24 h BCD display and hh:mm alarm pulse.
module clk_ss_gen #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned HOLD_TICKS    = 3000,
    parameter int unsigned REPEAT_TICKS  = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_ss_gen_if.slave   bus
);

    localparam int unsigned PW   = $clog2(TICKS_PER_SEC);
    localparam int unsigned CMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [CW-1:0] HOLD_C   = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] REP_C    = CW'(REPEAT_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [PW-1:0] r_pre;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_tgt_min;
    logic          r_sec_pulse;
    logic          r_alarm_hit;

    logic          w_any_btn;
    logic          w_tick;
    logic          w_tgt_btn;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_tgt_nxt;
    logic          w_step;
    logic [4:0]    w_hour_nxt;
    logic [5:0]    w_min_nxt;
    logic [5:0]    w_sec_nxt;
    logic          w_alarm_nxt;
    logic [5:0]    w_hour_disp;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign w_any_btn = bus.btn_clr | bus.btn_min | bus.btn_hour;
    assign w_tick    = !w_any_btn && (r_pre == PRE_LAST);
    assign w_tgt_btn = r_tgt_min ? bus.btn_min : bus.btn_hour;

    // Set FSM: press step, hold delay, then periodic auto-repeat on the latched button
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt_min;
        w_step      = 1'b0;
        if (bus.btn_clr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.btn_min || bus.btn_hour) begin
                        w_tgt_nxt   = bus.btn_min;
                        w_step      = 1'b1;
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (!w_tgt_btn) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == HOLD_C) begin
                        w_step      = 1'b1;
                        w_state_nxt = S_REPEAT;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                S_REPEAT: begin
                    if (!w_tgt_btn) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == REP_C) begin
                        w_step      = 1'b1;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Next time: clear beats set steps; ticks only happen with all buttons released
    always_comb begin
        w_hour_nxt = r_hour;
        w_min_nxt  = r_min;
        w_sec_nxt  = r_sec;
        if (bus.btn_clr) begin
            w_sec_nxt = '0;
        end else if (w_step) begin
            if (w_tgt_nxt) w_min_nxt  = (r_min  == 6'd59) ? '0 : r_min  + 6'd1;
            else           w_hour_nxt = (r_hour == 5'd23) ? '0 : r_hour + 5'd1;
        end else if (w_tick) begin
            if (r_sec == 6'd59) begin
                w_sec_nxt = '0;
                if (r_min == 6'd59) begin
                    w_min_nxt  = '0;
                    w_hour_nxt = (r_hour == 5'd23) ? '0 : r_hour + 5'd1;
                end else begin
                    w_min_nxt = r_min + 6'd1;
                end
            end else begin
                w_sec_nxt = r_sec + 6'd1;
            end
        end
        // Registered values are always in range, so out-of-range alarm settings never match
        w_alarm_nxt = w_tick && bus.alarm_en && (w_hour_nxt == bus.alarm_hour) &&
                      (w_min_nxt == bus.alarm_min) && (w_sec_nxt == 6'd0);
    end

    // State registers: prescaler, time, set FSM and the one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_hour      <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tgt_min   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_alarm_hit <= 1'b0;
        end else begin
            r_pre       <= (w_any_btn || w_tick) ? '0 : r_pre + PRE_ONE;
            r_hour      <= w_hour_nxt;
            r_min       <= w_min_nxt;
            r_sec       <= w_sec_nxt;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tgt_min   <= w_tgt_nxt;
            r_sec_pulse <= w_tick;
            r_alarm_hit <= w_alarm_nxt;
        end
    end

    // Displayed hour: 0 shows 12 and 13-23 fold to 1-11 in 12 h mode
    always_comb begin
        w_hour_disp = {1'b0, r_hour};
        if (bus.mode_12h) begin
            if (r_hour == 5'd0)       w_hour_disp = 6'd12;
            else if (r_hour > 5'd12)  w_hour_disp = {1'b0, r_hour - 5'd12};
        end
    end

    assign bus.time_bcd  = {to_bcd(w_hour_disp), to_bcd(r_min), to_bcd(r_sec)};
    assign bus.pm        = (r_hour >= 5'd12);
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.alarm_hit = r_alarm_hit;

endmodule

// File: tb/tb_clk_ss_gen.sv
// Self-checking bench for clk_ss_gen: seconds-of-day reference model compared every
// cycle, plus directed scenarios with literal expectations and a randomized phase.
module tb_clk_ss_gen;

    localparam int TPS = 10;
    localparam int HT  = 20;
    localparam int RT  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    clk_ss_gen_if bus ();

    clk_ss_gen #(
        .TICKS_PER_SEC (TPS),
        .HOLD_TICKS    (HT),
        .REPEAT_TICKS  (RT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int ah_seen = 0;

    // Reference model: time as seconds of day, button press age in cycles
    int m_tod;
    int m_pre;
    int m_age;
    bit m_tgt_min;
    bit m_sp;
    bit m_ah;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] exp_bcd();
        int h, hd;
        h  = m_tod / 3600;
        hd = bus.mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {bcd(hd), bcd((m_tod / 60) % 60), bcd(m_tod % 60)};
    endfunction

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_age = -1; m_tgt_min = 1'b0; m_sp = 1'b0; m_ah = 1'b0;
    endtask

    task automatic model_set_step();
        int h, m, s;
        h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
        if (m_tgt_min) m = (m + 1) % 60;
        else           h = (h + 1) % 24;
        m_tod = h * 3600 + m * 60 + s;
    endtask

    task automatic model_cycle();
        m_sp = 1'b0;
        m_ah = 1'b0;
        if (bus.btn_clr) begin
            m_tod = m_tod - (m_tod % 60);
            m_age = -1;
            m_pre = 0;
        end else if (bus.btn_min || bus.btn_hour) begin
            m_pre = 0;
            if (m_age < 0) begin
                m_tgt_min = bus.btn_min;
                m_age = 0;
                model_set_step();
            end else if (m_tgt_min ? bus.btn_min : bus.btn_hour) begin
                m_age++;
                if (m_age == HT || (m_age > HT && (m_age - HT) % RT == 0)) model_set_step();
            end else begin
                m_age = -1;
            end
        end else begin
            m_age = -1;
            m_pre++;
            if (m_pre == TPS) begin
                m_pre = 0;
                m_tod = (m_tod + 1) % 86400;
                m_sp  = 1'b1;
                if (bus.alarm_en && (m_tod % 60 == 0) && (m_tod / 3600 == int'(bus.alarm_hour)) &&
                    ((m_tod / 60) % 60 == int'(bus.alarm_min)))
                    m_ah = 1'b1;
            end
        end
    endtask

    // Compare process: model advances on each edge, DUT outputs checked 1 time unit later
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_cycle();
            #1;
            chk("time_bcd",  bus.time_bcd,        exp_bcd());
            chk("pm",        24'(bus.pm),         24'(m_tod >= 12 * 3600));
            chk("sec_pulse", 24'(bus.sec_pulse),  24'(m_sp));
            chk("alarm_hit", 24'(bus.alarm_hit),  24'(m_ah));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic press(input bit is_min, input int n);
        for (int i = 0; i < n; i++) begin
            if (is_min) bus.btn_min = 1'b1;
            else        bus.btn_hour = 1'b1;
            @(negedge clk);
            if (bus.alarm_hit) ah_seen++;
            bus.btn_min  = 1'b0;
            bus.btn_hour = 1'b0;
            @(negedge clk);
            if (bus.alarm_hit) ah_seen++;
        end
    endtask

    task automatic pulse_clr();
        bus.btn_clr = 1'b1;
        @(negedge clk);
        bus.btn_clr = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int got, c;
        got = 0; c = 0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.sec_pulse) got++;
        end
        chk("wait_pulses", 24'(got), 24'(n));
    endtask

    initial begin
        int np, n;
        logic [7:0] mn;
        bus.btn_clr = 1'b0; bus.btn_min = 1'b0; bus.btn_hour = 1'b0;
        bus.mode_12h = 1'b0; bus.alarm_en = 1'b0;
        bus.alarm_hour = '0; bus.alarm_min = '0;

        // Reset values in both display modes
        repeat (3) @(negedge clk);
        chk("reset_24h", bus.time_bcd, 24'h000000);
        bus.mode_12h = 1'b1;
        #1;
        chk("reset_12h", bus.time_bcd, 24'h120000);
        chk("reset_pm", 24'(bus.pm), 24'h0);
        bus.mode_12h = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 100 cycles give exactly 10 seconds
        np = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.sec_pulse) np++;
        end
        chk("pulse_count", 24'(np), 24'd10);
        chk("ten_seconds", bus.time_bcd, 24'h000010);
        chk("pm_low", 24'(bus.pm), 24'h0);

        // Preload 23:59:58 and roll over midnight
        press(1'b0, 23);
        press(1'b1, 59);
        pulse_clr();
        chk("preload", bus.time_bcd, 24'h235900);
        wait_pulses(58, 58 * TPS + 20);
        chk("pre_wrap", bus.time_bcd, 24'h235958);
        chk("pre_wrap_pm", 24'(bus.pm), 24'h1);
        repeat (20) @(negedge clk);
        chk("midnight", bus.time_bcd, 24'h000000);
        chk("midnight_pm", 24'(bus.pm), 24'h0);

        // Hold with auto-repeat from min=58; a hour press during the hold is ignored
        press(1'b1, 58);
        bus.btn_min = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            if (k == 10) bus.btn_hour = 1'b1;
            @(negedge clk);
            if (k == 0)  chk("hold_press", 24'(bus.time_bcd[23:8]), 24'h0059);
            if (k == 19) chk("hold_before", 24'(bus.time_bcd[23:8]), 24'h0059);
            if (k == 20) chk("hold_first", 24'(bus.time_bcd[23:8]), 24'h0000);
            if (k == 25) chk("repeat_1", 24'(bus.time_bcd[23:8]), 24'h0001);
            if (k == 30) chk("repeat_2", 24'(bus.time_bcd[23:8]), 24'h0002);
        end
        bus.btn_min = 1'b0; bus.btn_hour = 1'b0;
        @(negedge clk);

        // 12 h mapping at hours 0, 11, 12, 13
        bus.mode_12h = 1'b1;
        #1;
        chk("h12_0", 24'(bus.time_bcd[23:16]), 24'h12);
        chk("h12_0_pm", 24'(bus.pm), 24'h0);
        press(1'b0, 11);
        chk("h12_11", 24'(bus.time_bcd[23:16]), 24'h11);
        chk("h12_11_pm", 24'(bus.pm), 24'h0);
        press(1'b0, 1);
        chk("h12_12", 24'(bus.time_bcd[23:16]), 24'h12);
        chk("h12_12_pm", 24'(bus.pm), 24'h1);
        press(1'b0, 1);
        chk("h12_13", 24'(bus.time_bcd[23:16]), 24'h01);
        chk("h12_13_pm", 24'(bus.pm), 24'h1);

        // Asynchronous reset mid-count
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", bus.time_bcd, 24'h120000);
        chk("async_rst_pm", 24'(bus.pm), 24'h0);
        chk("async_rst_sp", 24'(bus.sec_pulse), 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mode_12h = 1'b0;

        // Alarm at 07:30 on tick, not on manual steps
        press(1'b0, 7);
        press(1'b1, 29);
        pulse_clr();
        bus.alarm_en = 1'b1; bus.alarm_hour = 5'd7; bus.alarm_min = 6'd30;
        wait_pulses(59, 59 * TPS + 20);
        chk("alarm_pre", bus.time_bcd, 24'h072959);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sec_pulse && n < 3 * TPS);
        chk("alarm_hit", 24'(bus.alarm_hit), 24'h1);
        chk("alarm_time", bus.time_bcd, 24'h073000);
        @(negedge clk);
        chk("alarm_one_cycle", 24'(bus.alarm_hit), 24'h0);
        ah_seen = 0;
        press(1'b1, 59);
        press(1'b1, 1);
        chk("alarm_step_min", 24'(bus.time_bcd[23:8]), 24'h0730);
        chk("alarm_manual", 24'(ah_seen), 24'h0);

        // Clear with btn_min at sec=45, then first tick exactly TPS cycles after release
        n = 0;
        while (bus.time_bcd[7:0] != 8'h45 && n < 70 * TPS) begin
            @(negedge clk);
            n++;
        end
        chk("reach_45", 24'(bus.time_bcd[7:0]), 24'h45);
        mn = bus.time_bcd[15:8];
        bus.btn_clr = 1'b1; bus.btn_min = 1'b1;
        repeat (3) @(negedge clk);
        chk("clr_sec", 24'(bus.time_bcd[7:0]), 24'h00);
        chk("clr_min", 24'(bus.time_bcd[15:8]), 24'(mn));
        bus.btn_clr = 1'b0; bus.btn_min = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sec_pulse && n < 3 * TPS);
        chk("clr_first_tick", 24'(n), 24'(TPS));

        // Randomized buttons, mode and alarm settings against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.btn_clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 4) bus.btn_min  = ~bus.btn_min;
            if ($urandom_range(0, 99) < 4) bus.btn_hour = ~bus.btn_hour;
            if ($urandom_range(0, 99) < 1) bus.mode_12h = ~bus.mode_12h;
            if (i % 200 == 0) begin
                bus.alarm_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 0) begin
                    bus.alarm_hour = 5'($urandom_range(0, 31));
                    bus.alarm_min  = 6'($urandom_range(0, 63));
                end else begin
                    bus.alarm_hour = 5'(m_tod / 3600);
                    bus.alarm_min  = 6'(((m_tod / 60) + 1) % 60);
                end
            end
        end
        bus.btn_clr = 1'b0; bus.btn_min = 1'b0; bus.btn_hour = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
